// File: rtl/afifo_wr_arb.sv
// afifo_wr_arb: round-robin arbiter sharing one AFIFO write port among NUM_REQ requesters.
// Latency: 1 cycle of arbitration in IDLE, then one beat per cycle; 1-cycle IDLE bubble between bursts.
// Backpressure: fifo_full drops req_ready and fifo_wr_en combinationally; beat count holds while full.
// Optional feature: define AFIFO_ARB_STAT_EN for per-requester saturating accepted-beat counters.
module afifo_wr_arb #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_BURST  = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_REQ-1:0]              req_valid,
  input  logic [NUM_REQ-1:0]              req_last,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data,
  output logic [NUM_REQ-1:0]              req_ready,
  input  logic                            fifo_full,
  output logic                            fifo_wr_en,
  output logic [DATA_WIDTH-1:0]           fifo_wdata,
  output logic [$clog2(NUM_REQ)-1:0]      grant_id,
  output logic                            busy,
  output logic [NUM_REQ*16-1:0]           stat_cnt
);

  localparam int ID_W = $clog2(NUM_REQ);
  localparam int BC_W = $clog2(MAX_BURST) + 1;

  typedef enum logic {IDLE, BURST} state_t;

  state_t            state, state_nxt;
  logic [ID_W-1:0]   grant_nxt;
  logic [ID_W-1:0]   last_grant, last_nxt;
  logic [BC_W-1:0]   beat_cnt, beat_nxt;
  logic [ID_W-1:0]   sel;
  logic [ID_W-1:0]   idx;
  logic              in_burst;
  logic              accept;
  logic              burst_end;

  // Round-robin pick: scan from last_grant+N down to last_grant+1 so the nearest valid wins.
  always_comb begin
    sel = last_grant;
    idx = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = ID_W'((int'(last_grant) + k) % NUM_REQ);
      if (req_valid[idx]) sel = idx;
    end
  end

  // Datapath outputs; reset gates them so an abandoned burst never writes in the reset cycle.
  always_comb begin
    in_burst   = (state == BURST) && !rst;
    req_ready  = '0;
    if (in_burst && !fifo_full) req_ready[grant_id] = 1'b1;
    fifo_wr_en = in_burst && req_valid[grant_id] && !fifo_full;
    fifo_wdata = req_data[DATA_WIDTH*int'(grant_id) +: DATA_WIDTH];
    accept     = fifo_wr_en;
    burst_end  = accept && (req_last[grant_id] || (beat_cnt == BC_W'(MAX_BURST - 1)));
  end

  assign busy = in_burst;

  // Next-state logic: grant in IDLE, count beats and release the lock in BURST.
  always_comb begin
    state_nxt = state;
    grant_nxt = grant_id;
    last_nxt  = last_grant;
    beat_nxt  = beat_cnt;
    case (state)
      IDLE: begin
        if (|req_valid) begin
          grant_nxt = sel;
          beat_nxt  = '0;
          state_nxt = BURST;
        end
      end
      BURST: begin
        if (accept) beat_nxt = beat_cnt + BC_W'(1);
        if (burst_end) begin
          state_nxt = IDLE;
          last_nxt  = grant_id;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register; reset restores requester 0 as first priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      grant_id   <= '0;
      last_grant <= ID_W'(NUM_REQ - 1);
      beat_cnt   <= '0;
    end else begin
      state      <= state_nxt;
      grant_id   <= grant_nxt;
      last_grant <= last_nxt;
      beat_cnt   <= beat_nxt;
    end
  end

`ifdef AFIFO_ARB_STAT_EN
  logic [15:0] stat_q [NUM_REQ];

  // Per-requester accepted-beat counters, saturating at all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REQ; i++) stat_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (accept && (grant_id == ID_W'(i)) && (stat_q[i] != 16'hFFFF))
          stat_q[i] <= stat_q[i] + 16'd1;
      end
    end
  end

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_stat
    assign stat_cnt[g*16 +: 16] = stat_q[g];
  end
`else
  assign stat_cnt = '0;
`endif

endmodule

// File: tb/tb_afifo_wr_arb.sv
// tb_afifo_wr_arb: directed bench for afifo_wr_arb with a per-cycle reference model and write log.
// Latency: inputs driven 1 time unit after posedge, outputs compared on negedge.
// Backpressure: requester sources hold each beat until the DUT accepts it.
module tb_afifo_wr_arb;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int MB = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid, req_last, req_ready;
  logic [N*DW-1:0] req_data;
  logic            fifo_full, fifo_wr_en;
  logic [DW-1:0]   fifo_wdata;
  logic [1:0]      grant_id;
  logic            busy;
  logic [N*16-1:0] stat_cnt;

  afifo_wr_arb #(.NUM_REQ(N), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_last(req_last),
    .req_data(req_data), .req_ready(req_ready), .fifo_full(fifo_full),
    .fifo_wr_en(fifo_wr_en), .fifo_wdata(fifo_wdata), .grant_id(grant_id),
    .busy(busy), .stat_cnt(stat_cnt)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // Requester sources: beat = {last, data}, popped once accepted.
  logic [DW:0] src_mem [N][64];
  int          src_head [N];
  int          src_tail [N];

  // DUT write log and handshake snapshot, written only by the compare process.
  int          wn = 0;
  int          cyc = 0;
  int          w_cyc [512];
  int          w_id  [512];
  logic [DW-1:0] w_dat [512];
  logic [N-1:0]  acc_seen = '0;

  // Reference model: owner of the write port (-1 when nobody holds it).
  int   m_owner = -1;
  int   m_prev  = N - 1;
  int   m_gid   = 0;
  int   m_beats = 0;
  int   m_cnt [N];
  bit   m_init  = 0;
  logic [N-1:0] e_ready;
  bit   e_busy, e_wr;

  function automatic logic [15:0] exp_stat(input int i);
`ifdef AFIFO_ARB_STAT_EN
    return 16'(m_cnt[i]);
`else
    return 16'd0;
`endif
  endfunction

  // Compare the DUT against the model every cycle, then advance the model one cycle.
  always @(negedge clk) begin
    cyc++;
    acc_seen = req_valid & req_ready;
    if (fifo_wr_en && wn < 512) begin
      w_cyc[wn] = cyc;
      w_id[wn]  = int'(grant_id);
      w_dat[wn] = fifo_wdata;
      wn++;
    end
    if (rst) begin
      check("rst_ready", req_ready, 0);
      check("rst_wr_en", fifo_wr_en, 0);
      check("rst_busy", busy, 0);
      if (m_init) begin
        check("rst_grant_id", grant_id, m_gid);
        for (int i = 0; i < N; i++) check("rst_stat", stat_cnt[i*16 +: 16], exp_stat(i));
      end
      m_owner = -1; m_prev = N - 1; m_gid = 0; m_beats = 0;
      for (int i = 0; i < N; i++) m_cnt[i] = 0;
      m_init = 1;
    end else if (m_init) begin
      e_busy  = (m_owner >= 0);
      e_ready = '0;
      if (e_busy && !fifo_full) e_ready[m_owner] = 1'b1;
      e_wr = e_busy && req_valid[m_owner] && !fifo_full;
      check("busy", busy, e_busy);
      check("req_ready", req_ready, e_ready);
      check("wr_en", fifo_wr_en, e_wr);
      check("grant_id", grant_id, m_gid);
      for (int i = 0; i < N; i++) check("stat_cnt", stat_cnt[i*16 +: 16], exp_stat(i));
      if (e_wr && fifo_wr_en) check("wdata", fifo_wdata, req_data[m_owner*DW +: DW]);
      if (m_owner < 0) begin
        for (int k = N; k >= 1; k--)
          if (req_valid[(m_prev + k) % N]) m_gid = (m_prev + k) % N;
        if (|req_valid) begin
          m_owner = m_gid;
          m_beats = 0;
        end
      end else if (e_wr) begin
        m_beats++;
        if (m_cnt[m_owner] < 65535) m_cnt[m_owner]++;
        if (req_last[m_owner] || m_beats == MB) begin
          m_prev  = m_owner;
          m_owner = -1;
        end
      end
    end
  end

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      if (src_head[i] < src_tail[i]) begin
        req_valid[i]         = 1'b1;
        req_last[i]          = src_mem[i][src_head[i]][DW];
        req_data[i*DW +: DW] = src_mem[i][src_head[i]][DW-1:0];
      end else begin
        req_valid[i]         = 1'b0;
        req_last[i]          = 1'b0;
        req_data[i*DW +: DW] = '0;
      end
    end
  endtask

  task automatic push(input int i, input logic [DW-1:0] d, input logic l);
    src_mem[i][src_tail[i]] = {l, d};
    src_tail[i]++;
  endtask

  task automatic clear_src();
    for (int i = 0; i < N; i++) src_head[i] = src_tail[i];
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++)
      if (acc_seen[i] && src_head[i] < src_tail[i]) src_head[i]++;
    drive();
  endtask

  function automatic bit pending();
    for (int i = 0; i < N; i++) if (src_head[i] < src_tail[i]) return 1'b1;
    return busy;
  endfunction

  task automatic wait_writes(input int b, input int n, input int maxc);
    int g;
    g = 0;
    while (wn - b < n && g < maxc) begin
      step();
      g++;
    end
    check("timeout_writes", (wn - b >= n), 1);
  endtask

  task automatic wait_idle(input int maxc);
    int g;
    g = 0;
    while (pending() && g < maxc) begin
      step();
      g++;
    end
    check("timeout_idle", !pending(), 1);
  endtask

  logic [DW-1:0] t2_dat [6] = '{32'hA0, 32'hA1, 32'hA2, 32'hB0, 32'hB1, 32'hB2};
  logic [DW-1:0] t5_dat [6] = '{32'hD0, 32'hD1, 32'hD2, 32'hD3, 32'hE0, 32'hE1};
  int            t5_id  [6] = '{1, 1, 1, 1, 3, 3};

  initial begin
    int b, bu, k, idv;
    rst = 1'b1; fifo_full = 1'b0;
    req_valid = '0; req_last = '0; req_data = '0;
    for (int i = 0; i < N; i++) begin
      src_head[i] = 0; src_tail[i] = 0; m_cnt[i] = 0;
    end

    // Reset held 2 cycles with every requester valid.
    for (int i = 0; i < N; i++) push(i, 32'h10 + 32'(i), 1'b1);
    drive();
    step();
    check("t1_ready", req_ready, 0);
    check("t1_wr_en", fifo_wr_en, 0);
    check("t1_busy", busy, 0);
    step();
    check("t1_grant_id", grant_id, 0);
    rst = 1'b0;
    b = wn;
    wait_idle(40);
    check("t1_nwrites", wn - b, 4);
    for (int j = 0; j < 4; j++) begin
      check("t1_order_id", w_id[b+j], j);
      check("t1_order_dat", w_dat[b+j], 32'h10 + 32'(j));
    end

    // Requester 2 alone: two 3-beat packets.
    b = wn;
    for (int j = 0; j < 6; j++) push(2, t2_dat[j], (j % 3) == 2);
    drive();
    wait_idle(50);
    check("t2_nwrites", wn - b, 6);
    for (int j = 0; j < 6; j++) begin
      check("t2_dat", w_dat[b+j], t2_dat[j]);
      check("t2_id", w_id[b+j], 2);
      if (j > 0) check("t2_gap", w_cyc[b+j] - w_cyc[b+j-1], (j == 3) ? 2 : 1);
    end

    // All four continuously valid, no last: bursts of MB, order 0,1,2,3,0.
    rst = 1'b1; step(); rst = 1'b0;
    b = wn;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < 8; j++) push(i, (32'(i) << 8) | 32'(j), 1'b0);
    drive();
    wait_writes(b, 20, 200);
    rst = 1'b1; clear_src(); drive(); step(); rst = 1'b0;
    for (int j = 0; j < 20; j++) begin
      bu  = j / 4;
      idv = bu % 4;
      k   = (bu / 4) * 4 + j % 4;
      check("t3_id", w_id[b+j], idv);
      check("t3_dat", w_dat[b+j], (32'(idv) << 8) | 32'(k));
      if (j > 0) check("t3_gap", w_cyc[b+j] - w_cyc[b+j-1], (j % 4 == 0) ? 2 : 1);
    end

    // fifo_full for 3 cycles after beat 2 of a 4-beat burst.
    b = wn;
    for (int j = 0; j < 4; j++) push(0, 32'hC0 + 32'(j), j == 3);
    drive();
    wait_writes(b, 2, 50);
    fifo_full = 1'b1;
    repeat (3) begin
      #1;
      check("t4_full_ready", req_ready, 0);
      check("t4_full_wr_en", fifo_wr_en, 0);
      step();
    end
    fifo_full = 1'b0;
    wait_idle(50);
    check("t4_nwrites", wn - b, 4);
    for (int j = 0; j < 4; j++) begin
      check("t4_dat", w_dat[b+j], 32'hC0 + 32'(j));
      check("t4_id", w_id[b+j], 0);
    end
    check("t4_stall_gap", w_cyc[b+2] - w_cyc[b+1], 4);

    // Reset after beat 1 of requester 1's burst, then 1 and 3 valid.
    b = wn;
    for (int j = 0; j < 4; j++) push(1, t5_dat[j], j == 3);
    drive();
    wait_writes(b, 1, 50);
    rst = 1'b1;
    push(3, t5_dat[4], 1'b0);
    push(3, t5_dat[5], 1'b1);
    drive();
    #1;
    check("t5_rst_wr_en", fifo_wr_en, 0);
    step();
    rst = 1'b0;
    wait_idle(60);
    check("t5_nwrites", wn - b, 6);
    for (int j = 0; j < 6; j++) begin
      check("t5_dat", w_dat[b+j], t5_dat[j]);
      check("t5_id", w_id[b+j], t5_id[j]);
    end
    check("t5_rst_gap", w_cyc[b+1] - w_cyc[b], 3);

    // Statistics: 8 beats from requester 0, 5 from requester 3.
    rst = 1'b1; step(); rst = 1'b0;
    b = wn;
    for (int j = 0; j < 8; j++) push(0, 32'h60 + 32'(j), 1'b0);
    for (int j = 0; j < 5; j++) push(3, 32'h30 + 32'(j), j == 4);
    drive();
    wait_idle(100);
    check("t6_nwrites", wn - b, 13);
`ifdef AFIFO_ARB_STAT_EN
    check("t6_stat0", stat_cnt[0*16 +: 16], 8);
    check("t6_stat1", stat_cnt[1*16 +: 16], 0);
    check("t6_stat2", stat_cnt[2*16 +: 16], 0);
    check("t6_stat3", stat_cnt[3*16 +: 16], 5);
`else
    check("t6_stat_all", stat_cnt, 0);
`endif

    repeat (3) step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
